// File: rtl/pa_dcache_dirty_bank.sv
// pa_dcache_dirty_bank: per-way dirty-bit store with a dirty-line scan engine for clean/flush.
// Optional dirty-bit counter on dirty_cnt when PA_DCACHE_DIRTY_CNT_EN is defined.
module pa_dcache_dirty_bank #(
    parameter int WAYS  = 4,
    parameter int IDX_W = 7,
    parameter int CNT_W = IDX_W + 4
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             acc_req,
    input  logic             acc_wr,
    input  logic [IDX_W-1:0] acc_idx,
    input  logic [WAYS-1:0]  acc_wen,
    input  logic [WAYS-1:0]  acc_din,
    output logic [WAYS-1:0]  acc_dout,
    output logic             acc_dout_vld,
    input  logic             scan_start,
    input  logic             scan_clr,
    input  logic             scan_abort,
    output logic             scan_busy,
    output logic             scan_vld,
    output logic [IDX_W-1:0] scan_idx,
    output logic [WAYS-1:0]  scan_way,
    input  logic             scan_rdy,
    output logic             scan_done,
    output logic [CNT_W-1:0] dirty_cnt
);
    localparam int DEPTH = 1 << IDX_W;
    typedef enum logic [2:0] {IDLE, RD, CHK, PRES, DONE} state_t;
    state_t           state;
    logic [WAYS-1:0]  mem [DEPTH];
    logic [IDX_W-1:0] ptr;
    logic             clr_mode;
    logic [WAYS-1:0]  scan_buf;
    logic             wr_en, wr_ptr, hs, clr_en, upd;
    logic [IDX_W-1:0] upd_idx;
    logic [WAYS-1:0]  old_row, new_row;
    // A write and a scan clear never share a cycle: scan_vld is low whenever acc_req is high.
    assign wr_en     = acc_req & acc_wr;
    assign wr_ptr    = wr_en & (acc_idx == ptr);
    assign scan_vld  = (state == PRES) & !acc_req;
    assign hs        = scan_vld & scan_rdy;
    assign clr_en    = hs & clr_mode & !scan_abort;
    assign upd       = wr_en | clr_en;
    assign upd_idx   = wr_en ? acc_idx : ptr;
    assign old_row   = mem[upd_idx];
    assign new_row   = wr_en ? (old_row & ~acc_wen) | (acc_din & acc_wen) : old_row & ~scan_way;
    assign scan_busy = state != IDLE;
    assign scan_done = state == DONE;
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (upd) begin
            mem[upd_idx] <= new_row;
        end
    end
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            acc_dout     <= '0;
            acc_dout_vld <= 1'b0;
        end else begin
            acc_dout_vld <= acc_req & !acc_wr;
            if (acc_req & !acc_wr) acc_dout <= mem[acc_idx];
        end
    end
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= IDLE;
            ptr      <= '0;
            clr_mode <= 1'b0;
            scan_buf <= '0;
            scan_idx <= '0;
            scan_way <= '0;
        end else if (state != IDLE && scan_abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (scan_start) begin
                    ptr      <= '0;
                    clr_mode <= scan_clr;
                    state    <= RD;
                end
                RD: if (!acc_req) begin
                    scan_buf <= mem[ptr];
                    state    <= CHK;
                end
                CHK: if (acc_req) begin
                    if (wr_ptr) state <= RD;
                end else if (scan_buf != '0) begin
                    scan_idx <= ptr;
                    scan_way <= scan_buf;
                    state    <= PRES;
                end else if (&ptr) begin
                    state <= DONE;
                end else begin
                    ptr   <= ptr + 1'b1;
                    state <= RD;
                end
                PRES: if (acc_req) begin
                    if (wr_ptr) state <= RD;
                end else if (scan_rdy) begin
                    if (&ptr) state <= DONE;
                    else begin
                        ptr   <= ptr + 1'b1;
                        state <= RD;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef PA_DCACHE_DIRTY_CNT_EN
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) dirty_cnt <= '0;
        else if (upd) dirty_cnt <= dirty_cnt + CNT_W'($countones(new_row)) - CNT_W'($countones(old_row));
    end
`else
    assign dirty_cnt = '0;
`endif
endmodule

// File: tb/tb_pa_dcache_dirty_bank.sv
// tb_pa_dcache_dirty_bank: directed checks of access port, scan engine, abort and async reset.
module tb_pa_dcache_dirty_bank;
    localparam int WAYS  = 4;
    localparam int IDX_W = 7;
    localparam int CNT_W = IDX_W + 4;
`ifdef PA_DCACHE_DIRTY_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic             clk = 1'b0;
    logic             rst_n;
    logic             acc_req, acc_wr;
    logic [IDX_W-1:0] acc_idx;
    logic [WAYS-1:0]  acc_wen, acc_din, acc_dout;
    logic             acc_dout_vld;
    logic             scan_start, scan_clr, scan_abort, scan_busy, scan_vld, scan_rdy, scan_done;
    logic [IDX_W-1:0] scan_idx;
    logic [WAYS-1:0]  scan_way;
    logic [CNT_W-1:0] dirty_cnt;
    int checks = 0;
    int failures = 0;
    int nhs, ndone;
    logic [IDX_W-1:0] i0, i1;
    logic [WAYS-1:0]  w0, w1;

    pa_dcache_dirty_bank #(.WAYS(WAYS), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .forever_cpuclk(clk), .cpurst_b(rst_n),
        .acc_req(acc_req), .acc_wr(acc_wr), .acc_idx(acc_idx), .acc_wen(acc_wen),
        .acc_din(acc_din), .acc_dout(acc_dout), .acc_dout_vld(acc_dout_vld),
        .scan_start(scan_start), .scan_clr(scan_clr), .scan_abort(scan_abort),
        .scan_busy(scan_busy), .scan_vld(scan_vld), .scan_idx(scan_idx), .scan_way(scan_way),
        .scan_rdy(scan_rdy), .scan_done(scan_done), .dirty_cnt(dirty_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [IDX_W-1:0] idx, input logic [WAYS-1:0] wen, input logic [WAYS-1:0] din);
        acc_req = 1'b1; acc_wr = 1'b1; acc_idx = idx; acc_wen = wen; acc_din = din;
        cyc;
        acc_req = 1'b0; acc_wr = 1'b0;
    endtask

    task automatic rd(input logic [IDX_W-1:0] idx);
        acc_req = 1'b1; acc_wr = 1'b0; acc_idx = idx;
        cyc;
        acc_req = 1'b0;
    endtask

    task automatic run_scan(input logic clr);
        nhs = 0; ndone = 0; i0 = '0; i1 = '0; w0 = '0; w1 = '0;
        scan_start = 1'b1; scan_clr = clr; scan_rdy = 1'b1;
        cyc;
        scan_start = 1'b0; scan_clr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (scan_vld) begin
                if (nhs == 0) begin i0 = scan_idx; w0 = scan_way; end
                else begin i1 = scan_idx; w1 = scan_way; end
                nhs++;
            end
            if (scan_done) begin
                ndone++;
                break;
            end
            cyc;
        end
        cyc;
        scan_rdy = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        for (int i = 0; i < 400 && !scan_vld; i++) cyc;
        chk(tag, {31'd0, scan_vld}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        {acc_req, acc_wr, scan_start, scan_clr, scan_abort, scan_rdy} = '0;
        acc_idx = '0; acc_wen = '0; acc_din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", acc_dout, 0);
        chk("rst_dout_vld", acc_dout_vld, 0);
        chk("rst_busy", scan_busy, 0);
        chk("rst_vld", scan_vld, 0);
        chk("rst_done", scan_done, 0);
        chk("rst_cnt", dirty_cnt, 0);
        rst_n = 1'b1;
        cyc;

        rd(7'd5);
        chk("rd5_dout", acc_dout, 0);
        chk("rd5_vld", acc_dout_vld, 1);
        chk("rd5_cnt", dirty_cnt, 0);
        cyc;
        chk("rd5_vld_drop", acc_dout_vld, 0);

        wr(7'd3, 4'b0101, 4'b0101);
        wr(7'd3, 4'b0010, 4'b1111);
        rd(7'd3);
        chk("rd3_merge", acc_dout, 4'b0111);
        chk("rd3_cnt", dirty_cnt, CNT_EN ? 3 : 0);
        wr(7'd3, 4'b1111, 4'b0000);

        wr(7'd0, 4'b1111, 4'b0001);
        wr(7'd127, 4'b1111, 4'b1000);
        chk("pre_scan_cnt", dirty_cnt, CNT_EN ? 2 : 0);
        run_scan(1'b0);
        chk("scan_nhs", nhs, 2);
        chk("scan_i0", i0, 0);
        chk("scan_w0", w0, 4'b0001);
        chk("scan_i1", i1, 127);
        chk("scan_w1", w1, 4'b1000);
        chk("scan_ndone", ndone, 1);
        chk("scan_busy_end", scan_busy, 0);
        chk("scan_done_1cyc", scan_done, 0);
        rd(7'd0);
        chk("noclr_rd0", acc_dout, 4'b0001);
        rd(7'd127);
        chk("noclr_rd127", acc_dout, 4'b1000);

        run_scan(1'b1);
        chk("clr_nhs", nhs, 2);
        chk("clr_ndone", ndone, 1);
        rd(7'd0);
        chk("clr_rd0", acc_dout, 0);
        rd(7'd127);
        chk("clr_rd127", acc_dout, 0);
        chk("clr_cnt", dirty_cnt, 0);

        wr(7'd9, 4'b1111, 4'b0010);
        scan_start = 1'b1; scan_clr = 1'b1; scan_rdy = 1'b0;
        cyc;
        scan_start = 1'b0; scan_clr = 1'b0;
        wait_vld("pres9_vld");
        chk("pres9_idx", scan_idx, 9);
        chk("pres9_way", scan_way, 4'b0010);
        acc_req = 1'b1; acc_wr = 1'b1; acc_idx = 7'd9; acc_wen = 4'b0001; acc_din = 4'b0001;
        #1;
        chk("hold_vld0", scan_vld, 0);
        cyc;
        acc_wr = 1'b0; acc_idx = 7'd20;
        #1;
        chk("hold_vld1", scan_vld, 0);
        cyc;
        #1;
        chk("hold_vld2", scan_vld, 0);
        cyc;
        acc_req = 1'b0;
        wait_vld("repres_vld");
        chk("repres_idx", scan_idx, 9);
        chk("repres_way", scan_way, 4'b0011);
        chk("repres_cnt", dirty_cnt, CNT_EN ? 2 : 0);

        scan_rdy = 1'b1; scan_abort = 1'b1;
        cyc;
        scan_rdy = 1'b0; scan_abort = 1'b0;
        chk("abort_vld", scan_vld, 0);
        chk("abort_busy", scan_busy, 0);
        chk("abort_done", scan_done, 0);
        cyc;
        chk("abort_done_late", scan_done, 0);
        rd(7'd9);
        chk("abort_noclr", acc_dout, 4'b0011);
        chk("abort_cnt", dirty_cnt, CNT_EN ? 2 : 0);

        scan_start = 1'b1; scan_clr = 1'b0;
        cyc;
        scan_start = 1'b0;
        wait_vld("pre_rst_vld");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", scan_busy, 0);
        chk("arst_vld", scan_vld, 0);
        chk("arst_idx", scan_idx, 0);
        chk("arst_way", scan_way, 0);
        chk("arst_dout", acc_dout, 0);
        chk("arst_dout_vld", acc_dout_vld, 0);
        chk("arst_cnt", dirty_cnt, 0);
        cyc;
        rst_n = 1'b1;
        cyc;
        rd(7'd9);
        chk("arst_rd9", acc_dout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pa_dcache_dirty_bank.md
Name: pa_dcache_dirty_bank

Overview:
Parametrised D-cache dirty-bit store: one dirty bit per way per set, flop-based, single access port with registered read data. Adds a built-in dirty-line scan engine for cache clean/flush. The engine walks all sets, presents each set with any dirty way over a valid/ready handshake, and can optionally clear the bits it hands off. Sits in the LSU beside the tag/data arrays and serves the dcache control and the CP0 clean/flush sequencer.

Parameters:
WAYS, 4, number of ways (dirty bits per set), 1..8
IDX_W, 7, set-index width; DEPTH = 2^IDX_W sets (7 = 8K, 4-way)
CNT_W, IDX_W+4, dirty-line counter width (only with PA_DCACHE_DIRTY_CNT_EN)

Ports:
forever_cpuclk  in  1  free-running CPU clock
cpurst_b  in  1  asynchronous active-low reset
acc_req  in  1  access request, single cycle, no stall
acc_wr  in  1  1=write, 0=read
acc_idx  in  IDX_W  set index
acc_wen  in  WAYS  per-way write enable, active-high
acc_din  in  WAYS  write data per way
acc_dout  out  WAYS  read data, registered
acc_dout_vld  out  1  read data valid pulse
scan_start  in  1  start a full scan, pulse
scan_clr  in  1  sampled with scan_start: clear bits on handoff
scan_abort  in  1  terminate scan
scan_busy  out  1  scan engine not IDLE
scan_vld  out  1  dirty set presented
scan_idx  out  IDX_W  presented set index
scan_way  out  WAYS  dirty-way vector of presented set
scan_rdy  in  1  consumer accepts presented set
scan_done  out  1  one-cycle pulse at scan completion
dirty_cnt  out  CNT_W  total dirty bits (optional feature)

Behaviour:
- One clock (forever_cpuclk); reset asynchronous active-low (cpurst_b).
- Reset: all array bits 0, acc_dout=0, acc_dout_vld=0, scan_busy=0, scan_vld=0, scan_idx=0, scan_way=0, scan_done=0, dirty_cnt=0, FSM=IDLE.
- Write (acc_req&acc_wr): at the clock edge, bit[acc_idx][w] <= acc_din[w] for each w with acc_wen[w]=1; other ways unchanged.
- Read (acc_req&!acc_wr): acc_dout = array[acc_idx] and acc_dout_vld=1 in the next cycle. acc_dout holds its value otherwise; acc_dout_vld=0 otherwise.
- Read in cycle N+1 after a write in cycle N to the same index returns the new data.
- Access always has priority over the scan engine; the scan stalls in any cycle with acc_req=1.
- Scan FSM states: IDLE, RD, CHK, PRES, DONE. Pointer ptr has width IDX_W.
- IDLE: on scan_start, ptr=0, latch clr_mode=scan_clr, go to RD. scan_start while busy is ignored.
- RD: if acc_req=0, read array[ptr] into the scan buffer and go to CHK; otherwise stay in RD.
- CHK: if the buffer is 0 -> advance; else scan_idx=ptr, scan_way=buffer, go to PRES.
- PRES: scan_vld = !acc_req.
  - Handshake (scan_vld&scan_rdy): if clr_mode, clear bits scan_way at ptr in the same edge; then advance.
  - An access write to acc_idx==ptr while in PRES: scan_vld=0, go back to RD to re-read. This also applies when the write coincides with scan_rdy, since scan_vld is 0 in that cycle.
- Advance: if ptr==DEPTH-1 go to DONE; else ptr+1 and go to RD. There is no wrap-around.
- DONE: scan_done=1 for one cycle, then IDLE.
- scan_abort (any non-IDLE state): IDLE next cycle, scan_vld=0, no scan_done pulse, bits already cleared stay cleared. scan_abort has priority over a same-cycle handshake; no clear occurs.
- scan_busy=1 in every state except IDLE.
- scan_vld drops the cycle after a handshake.
- Throughput: a clean set costs 2 cycles; a dirty set costs at least 3.

Optional Feature:
Macro PA_DCACHE_DIRTY_CNT_EN.
- Defined: dirty_cnt tracks the total number of 1 bits in the array.
  - Each edge it adds the number of 0->1 transitions and subtracts the number of 1->0 transitions caused by that cycle's write or scan clear.
  - Saturates at neither end; width CNT_W guarantees no overflow.
- Undefined: no counter logic; dirty_cnt is tied to 0 and the port remains.

Test Plan:
- Reset, then read idx 5 -> acc_dout=0 and acc_dout_vld=1 one cycle after the request; dirty_cnt=0.
- Write idx 3, wen=0101, din=0101; next cycle write idx 3, wen=0010, din=1111; then read idx 3 -> acc_dout=0111, dirty_cnt=3.
- Set bits at idx 0 (0001) and idx DEPTH-1 (1000); scan_start with scan_clr=0; scan_rdy held 1 -> exactly two handshakes (idx 0/0001, idx DEPTH-1/1000), then scan_done one pulse, scan_busy=0, array unchanged.
- Same array, scan_clr=1 -> after scan_done, reads of both indices return 0000 and dirty_cnt=0.
- Scan presenting idx 9 (way 0010) with scan_rdy=0; access write idx 9 wen=0001 din=0001 -> scan_vld drops, re-presents idx 9 with scan_way=0011; acc_req held for 3 cycles -> scan_vld=0 in those cycles.
- Mid-scan scan_abort with scan_rdy=1 in the same cycle -> no clear, scan_vld=0 next cycle, FSM IDLE, no scan_done; async cpurst_b low mid-scan -> all outputs at reset values immediately.
